fp16_image_packer: RTL

FP16_IMAGE_PACKER -- requirements
Module: fp16_image_packer

---
 rtl/fp16_image_packer_pkg.sv | 17 +
 rtl/fp16_image_packer_if.sv | 17 +
 rtl/fp16_image_packer_fp16_to_fp8.sv | 26 ++
 rtl/fp16_image_packer.sv | 62 ++++++
 4 files changed

// File: rtl/fp16_image_packer_pkg.sv
// fp16_image_packer_pkg: shared widths, limits and helpers for the FP16 -> 8-bit image packer.
package fp16_image_packer_pkg;
  localparam int LANES      = 9;
  localparam int ELEM_W     = 8;
  localparam int WORD_W     = LANES * ELEM_W;
  localparam int CNT_W      = 4;
  localparam int FP16_BIAS  = 15;
  localparam int EXP_MAX_T  = 15;
  localparam int F16_EXP_W  = 5;
  localparam int F16_MANT_W = 10;
  localparam int E_EXP_W    = 4;
  localparam int E_MANT_W   = 3;
  localparam int T_W        = 7;
  function automatic logic [ELEM_W-1:0] sat_elem(input logic sign);
    return {sign, {E_EXP_W{1'b1}}, {E_MANT_W{1'b1}}};
  endfunction
endpackage

// File: rtl/fp16_image_packer_if.sv
// fp16_image_packer_if: element input stream, layer bias, flush and 72-bit output word handshake.
// master drives in_valid/in_data/exp_bias/flush/out_ready; slave (the packer) drives in_ready/out_valid/out_image.
interface fp16_image_packer_if;
  import fp16_image_packer_pkg::*;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              in_ready;
  logic [4:0]        exp_bias;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_image;
  modport master (output in_valid, in_data, exp_bias, flush, out_ready,
                  input  in_ready, out_valid, out_image);
  modport slave  (input  in_valid, in_data, exp_bias, flush, out_ready,
                  output in_ready, out_valid, out_image);
endinterface

// File: rtl/fp16_image_packer_fp16_to_fp8.sv
// fp16_to_fp8: combinational FP16 -> 8-bit element {sign, exp[3:0], mant[2:0]} with layer bias.
// Ports: in_data (FP16), exp_bias (5-bit layer bias) -> elem (8-bit element).
module fp16_to_fp8
  import fp16_image_packer_pkg::*;
(
  input  logic [15:0]       in_data,
  input  logic [4:0]        exp_bias,
  output logic [ELEM_W-1:0] elem
);
  localparam logic signed [T_W-1:0] T_MAX = T_W'(EXP_MAX_T);
  logic                  sign;
  logic [F16_EXP_W-1:0]  e;
  logic [E_MANT_W:0]     m_rnd;
  logic signed [T_W-1:0] t;
  assign sign  = in_data[15];
  assign e     = in_data[14:10];
  // round half up on mant[6]; a carry out of the 3-bit mantissa leaves m_rnd[2:0] zero and bumps t
  assign m_rnd = {1'b0, in_data[9:7]} + {{E_MANT_W{1'b0}}, in_data[6]};
  assign t     = T_W'(e) - T_W'(exp_bias) + T_W'(m_rnd[E_MANT_W]);
  // Inf/NaN saturate ahead of the underflow test so they never collapse to zero
  always_comb
    elem = (e == '0) ? '0 :
           (e == '1 || t > T_MAX) ? sat_elem(sign) :
           (t[T_W-1] || t == '0) ? '0 :
           {sign, t[E_EXP_W-1:0], m_rnd[E_MANT_W-1:0]};
endmodule

// File: rtl/fp16_image_packer.sv
// fp16_image_packer: packs nine converted 8-bit elements per 72-bit word with flush and output stall.
// Ports: clk, rst (async, active-high), bus (fp16_image_packer_if.slave: input stream, exp_bias, flush, output word).
module fp16_image_packer
  import fp16_image_packer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fp16_image_packer_if.slave bus
);
  logic [ELEM_W-1:0] elem;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] acc, word, out_image;
  logic              pend, out_valid, ready, accept, full, flush_req, can_load, xfer;
  fp16_to_fp8 u_conv (
    .in_data  (bus.in_data),
    .exp_bias (bus.exp_bias),
    .elem     (elem)
  );
  assign can_load      = !out_valid || bus.out_ready;
  // a held flush blocks input so the partial word cannot grow while waiting for the output
  assign ready         = !pend && !(cnt == CNT_W'(LANES-1) && out_valid && !bus.out_ready);
  assign accept        = bus.in_valid && ready;
  assign full          = accept && cnt == CNT_W'(LANES-1);
  assign flush_req     = (bus.flush || pend) && (cnt != '0 || accept);
  assign xfer          = full || (flush_req && can_load);
  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid;
  assign bus.out_image = out_image;
  // lanes at or beyond cnt are always zero in acc, so a partial word is already zero-padded
  always_comb begin
    word = acc;
    for (int i = 0; i < LANES; i++)
      if (accept && cnt == CNT_W'(i)) word[i*ELEM_W +: ELEM_W] = elem;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_image <= '0;
    end else begin
      if (xfer) begin
        cnt  <= '0;
        acc  <= '0;
        pend <= 1'b0;
      end else begin
        if (accept) begin
          cnt <= cnt + CNT_W'(1);
          acc <= word;
        end
        pend <= flush_req;
      end
      if (xfer) begin
        out_image <= word;
        out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
